// File: rtl/vga_debug_pkg.sv
// Shared types and constants for the VGA debug text reader.
// State enum, ASCII codes, row-word field positions and column layout.
package vga_debug_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      EMIT
   } state_t;

   localparam logic [7:0] ASCII_SPACE      = 8'h20;
   localparam logic [7:0] ASCII_ZERO       = 8'h30;
   localparam logic [7:0] ASCII_A_MINUS_10 = 8'h37;

   localparam int ROW_CHARS_DEF = 35;

   // Low bit of each 32-bit field in the 128-bit row word
   localparam logic [6:0] INSTR_LSB = 7'd96;
   localparam logic [6:0] INT_LSB   = 7'd64;
   localparam logic [6:0] FLOAT_LSB = 7'd32;
   localparam logic [6:0] DATA_LSB  = 7'd0;

   // First text column of each field
   localparam logic [5:0] COL_F0 = 6'd0;
   localparam logic [5:0] COL_F1 = 6'd9;
   localparam logic [5:0] COL_F2 = 6'd18;
   localparam logic [5:0] COL_F3 = 6'd27;

   localparam logic [5:0] FIELD_DIGITS = 6'd8;

   function automatic logic [6:0] field_lsb(input logic [1:0] fld);
      logic [6:0] r;
      unique case (fld)
         2'd0:    r = INSTR_LSB;
         2'd1:    r = INT_LSB;
         2'd2:    r = FLOAT_LSB;
         default: r = DATA_LSB;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/vga_hex_to_ascii.sv
// Combinational nibble to uppercase ASCII hex digit converter.
// Ports: nibble (4-bit value in), ascii (8-bit character out).
module vga_hex_to_ascii
   import vga_debug_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] ascii
);

   always_comb begin
      if (nibble < 4'd10) begin
         ascii = ASCII_ZERO + {4'd0, nibble};
      end else begin
         ascii = ASCII_A_MINUS_10 + {4'd0, nibble};
      end
   end

endmodule

// File: rtl/vga_debug_text_reader.sv
// Walks shadow RAM rows per frame and streams them as ASCII hex text.
// Ports: clk, rst_n, frame_start, read_address/ram_out (RAM side),
//   char_data/col/row/valid/ready (text stream), busy, frame_done.
module vga_debug_text_reader
   import vga_debug_pkg::*;
#(
   parameter int NUM_ROWS  = 46,
   parameter int REG_ROWS  = 32,
   parameter int ROW_CHARS = ROW_CHARS_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         frame_start,
   output logic [5:0]   read_address,
   input  logic [127:0] ram_out,
   output logic [7:0]   char_data,
   output logic [5:0]   char_col,
   output logic [5:0]   char_row,
   output logic         char_valid,
   input  logic         char_ready,
   output logic         busy,
   output logic         frame_done
);

   localparam logic [5:0] LAST_COL = 6'(ROW_CHARS - 1);
   localparam logic [5:0] LAST_ROW = 6'(NUM_ROWS - 1);
   localparam logic [6:0] REG_LIM  = 7'(REG_ROWS);

   state_t         state;
   logic [127:0]   row_q;

   logic [127:0]   src;
   logic [5:0]     sel;
   logic [1:0]     fld;
   logic [2:0]     dig;
   logic           is_space;
   logic [6:0]     idx;
   logic [3:0]     nib;
   logic [7:0]     hex_char;
   logic [7:0]     next_char;

   assign char_row = read_address;

   // The character register is loaded one column ahead: in FETCH it
   // takes column 0 straight from the RAM, in EMIT it takes col+1
   // from the latched row.
   always_comb begin
      src      = (state == FETCH) ? ram_out : row_q;
      sel      = (state == FETCH) ? 6'd0 : char_col + 6'd1;
      fld      = 2'd0;
      dig      = 3'd0;
      is_space = 1'b0;
      unique case (1'b1)
         (sel < COL_F0 + FIELD_DIGITS): begin
            fld = 2'd0;
            dig = 3'(sel - COL_F0);
         end
         (sel >= COL_F1 && sel < COL_F1 + FIELD_DIGITS): begin
            fld = 2'd1;
            dig = 3'(sel - COL_F1);
         end
         (sel >= COL_F2 && sel < COL_F2 + FIELD_DIGITS): begin
            fld = 2'd2;
            dig = 3'(sel - COL_F2);
         end
         (sel >= COL_F3 && sel < COL_F3 + FIELD_DIGITS): begin
            fld = 2'd3;
            dig = 3'(sel - COL_F3);
         end
         default: is_space = 1'b1;
      endcase
      // High rows alias register entries, so hide both reg fields
      if ({1'b0, read_address} >= REG_LIM &&
          (fld == 2'd1 || fld == 2'd2)) begin
         is_space = 1'b1;
      end
      idx = field_lsb(fld) + 7'd28 - {2'b00, dig, 2'b00};
      nib = src[idx +: 4];
   end

   vga_hex_to_ascii u_hex (
      .nibble (nib),
      .ascii  (hex_char)
   );

   assign next_char = is_space ? ASCII_SPACE : hex_char;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         read_address <= 6'd0;
         row_q        <= '0;
         char_data    <= 8'd0;
         char_col     <= 6'd0;
         char_valid   <= 1'b0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (frame_start) begin
                  state        <= FETCH;
                  read_address <= 6'd0;
                  busy         <= 1'b1;
               end
            end
            FETCH: begin
               row_q      <= ram_out;
               char_col   <= 6'd0;
               char_data  <= next_char;
               char_valid <= 1'b1;
               state      <= EMIT;
            end
            EMIT: begin
               if (char_ready) begin
                  if (char_col < LAST_COL) begin
                     char_col  <= char_col + 6'd1;
                     char_data <= next_char;
                  end else begin
                     char_valid <= 1'b0;
                     char_col   <= 6'd0;
                     if (read_address < LAST_ROW) begin
                        read_address <= read_address + 6'd1;
                        state        <= FETCH;
                     end else begin
                        read_address <= 6'd0;
                        busy         <= 1'b0;
                        frame_done   <= 1'b1;
                        state        <= IDLE;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_debug_text_reader.sv
// Scoreboard bench for vga_debug_text_reader.
// Expected characters are queued per frame; a monitor pops on transfer.
module tb_vga_debug_text_reader;

   typedef struct {
      logic [7:0] d;
      logic [5:0] col;
      logic [5:0] row;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         frame_start;
   logic [5:0]   read_address;
   logic [127:0] ram_out;
   logic [7:0]   char_data;
   logic [5:0]   char_col;
   logic [5:0]   char_row;
   logic         char_valid;
   logic         char_ready;
   logic         busy;
   logic         frame_done;

   logic [127:0] mem [64];
   exp_t         q[$];
   int           tests;
   int           fails;
   int           xfer_cnt;
   int           done_cnt;
   int           mode;
   int           cyc;

   assign ram_out = mem[read_address];

   vga_debug_text_reader dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .frame_start  (frame_start),
      .read_address (read_address),
      .ram_out      (ram_out),
      .char_data    (char_data),
      .char_col     (char_col),
      .char_row     (char_row),
      .char_valid   (char_valid),
      .char_ready   (char_ready),
      .busy         (busy),
      .frame_done   (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic string hx(input logic [3:0] n);
      logic [7:0] c;
      c = (n < 4'd10) ? 8'h30 + {4'd0, n} : 8'h37 + {4'd0, n};
      return $sformatf("%c", c);
   endfunction

   function automatic string row_str(input int r);
      string      s;
      logic [127:0] w;
      logic [3:0] n;
      s = "";
      w = mem[r];
      for (int f = 0; f < 4; f++) begin
         if (f != 0) s = {s, " "};
         for (int d = 0; d < 8; d++) begin
            n = w[127 - 32*f - 4*d -: 4];
            if (r >= 32 && (f == 1 || f == 2)) s = {s, " "};
            else s = {s, hx(n)};
         end
      end
      return s;
   endfunction

   task automatic push_frame;
      string s;
      exp_t  e;
      for (int r = 0; r < 46; r++) begin
         if (r == 0) s = "12345678 9ABCDEF0 0000000F DEADBEEF";
         else if (r == 32) s = "CAFEF00D                   0BADC0DE";
         else s = row_str(r);
         for (int c = 0; c < 35; c++) begin
            e.d   = s[c];
            e.col = 6'(c);
            e.row = 6'(r);
            q.push_back(e);
         end
      end
   endtask

   task automatic start_frame;
      xfer_cnt = 0;
      done_cnt = 0;
      push_frame();
      frame_start = 1'b1;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      check("valid_after_e0", {63'd0, char_valid}, 64'd0);
      check("busy_after_e0", {63'd0, busy}, 64'd1);
      @(posedge clk);
      #1;
      check("valid_after_e1", {63'd0, char_valid}, 64'd1);
   endtask

   task automatic wait_done(input int max);
      bit found;
      found = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (frame_done) begin
            found = 1'b1;
            break;
         end
      end
      check("frame_done_seen", {63'd0, found}, 64'd1);
      check("busy_at_done", {63'd0, busy}, 64'd0);
      check("addr_at_done", {58'd0, read_address}, 64'd0);
      check("valid_at_done", {63'd0, char_valid}, 64'd0);
      repeat (4) @(negedge clk);
      check("done_pulses", 64'(done_cnt), 64'd1);
      check("xfer_count", 64'(xfer_cnt), 64'd1610);
      check("queue_empty", 64'(q.size()), 64'd0);
   endtask

   task automatic check_zero(input string name);
      check(name, {27'd0, read_address, char_data, char_col, char_row,
                   char_valid, busy, frame_done}, 64'd0);
   endtask

   // Ready driver: mode 0 always ready, mode 1 a repeating
   // 1,1,1,0,0,1,1 pattern giving two-cycle stalls mid-row.
   initial begin
      char_ready = 1'b1;
      cyc = 0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (mode == 0) char_ready = 1'b1;
         else char_ready = (cyc % 7 != 3) && (cyc % 7 != 4);
      end
   end

   // Monitor: pops and compares on every accepted character
   always @(negedge clk) begin
      if (rst_n && frame_done) done_cnt++;
      if (rst_n && char_valid && char_ready) begin
         xfer_cnt++;
         tests++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_char: got %0h col %0d row %0d, expected none",
                     char_data, char_col, char_row);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (char_data !== e.d || char_col !== e.col ||
                char_row !== e.row) begin
               fails++;
               $display("FAIL char: got %0h c%0d r%0d expected %0h c%0d r%0d",
                        char_data, char_col, char_row, e.d, e.col, e.row);
            end
         end
      end
   end

   initial begin
      bit hit;
      tests = 0;
      fails = 0;
      xfer_cnt = 0;
      done_cnt = 0;
      mode = 0;
      frame_start = 1'b0;
      rst_n = 1'b0;
      for (int r = 0; r < 64; r++) begin
         mem[r] = {32'(r) * 32'h01234567, 32'h89ABCDEF ^ 32'(r),
                   32'h00F0_0000 + 32'(r), 32'hFEDC_BA98 - 32'(r)};
      end
      mem[0]  = {32'h12345678, 32'h9ABCDEF0, 32'h0000000F, 32'hDEADBEEF};
      mem[32] = {32'hCAFEF00D, 32'h11111111, 32'h22222222, 32'h0BADC0DE};
      #1;
      check_zero("reset_outputs");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_zero("idle_outputs");

      // Frame with periodic backpressure
      mode = 1;
      start_frame();
      wait_done(4000);

      // Frame at full rate with ignored mid-frame frame_start pulses
      mode = 0;
      start_frame();
      repeat (300) @(posedge clk);
      #1;
      frame_start = 1'b1;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      repeat (500) @(posedge clk);
      #1;
      frame_start = 1'b1;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      wait_done(2000);

      // Reset in the middle of row 5, column 12
      start_frame();
      hit = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (char_valid && char_row == 6'd5 && char_col == 6'd12) begin
            hit = 1'b1;
            break;
         end
      end
      check("reached_r5c12", {63'd0, hit}, 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check_zero("async_reset_clear");
      q.delete();
      done_cnt = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("no_done_after_abort", 64'(done_cnt), 64'd0);
      check_zero("idle_after_abort");
      @(posedge clk);
      #1;
      start_frame();
      wait_done(2000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vga_debug_text_reader.md
Name: vga_debug_text_reader

Overview:
- Read-side consumer of the VGA debug shadow RAM (instr / int reg / float reg / data mirrors).
- On each frame request, walks shadow rows 0..NUM_ROWS-1 by driving the RAM read address and latching the 128-bit row word.
- Converts each row word to ASCII hex text and streams one character per handshake into the VGA text-line buffer / glyph stage.

Parameters:
- NUM_ROWS, 46, number of shadow rows scanned per frame (1..64).
- REG_ROWS, 32, rows that carry valid int/float register fields; rows at or above this blank those fields.
- ROW_CHARS, 35, characters emitted per row (4 fields x 8 hex digits + 3 separators).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  single-cycle request to render one full frame of debug text.
- read_address  out  6  row address to shadow RAM.
- ram_out  in  128  row word from shadow RAM: [127:96] instr, [95:64] int reg, [63:32] float reg, [31:0] data; combinational from read_address.
- char_data  out  8  ASCII character.
- char_col  out  6  column 0..ROW_CHARS-1 of char_data.
- char_row  out  6  row 0..NUM_ROWS-1 of char_data.
- char_valid  out  1  char_data/col/row valid.
- char_ready  in  1  downstream accepts the character when high with char_valid.
- busy  out  1  high from the cycle after frame_start is accepted until frame_done.
- frame_done  out  1  single-cycle pulse after the last character of the last row is accepted.

Behaviour:
- Reset: the asynchronous assert forces state IDLE. It also forces read_address, char_data, char_col, char_row, char_valid, busy, frame_done and the row latch to 0.
- States: IDLE, FETCH, EMIT.
- IDLE: frame_start=1 at edge E0 moves the block to FETCH, sets read_address<=0 and busy<=1. frame_start is ignored while busy.
- FETCH: lasts exactly one cycle. At the next edge the 128-bit ram_out is latched into the row register, col<=0 and state<=EMIT. Therefore char_valid first rises after E0+2 edges.
- EMIT: char_valid=1. The character at col is derived from the latched row only; later ram_out changes have no effect.
  - Cols 0-7: instr nibbles [127:124] down to [99:96].
  - Col 8: space (0x20).
  - Cols 9-16: int reg nibbles, MSB nibble first.
  - Col 17: space.
  - Cols 18-25: float reg nibbles.
  - Col 26: space.
  - Cols 27-34: data nibbles.
- Hex encoding: nibble 0-9 maps to 0x30-0x39; A-F maps to 0x41-0x46 (uppercase).
- Rows >= REG_ROWS: cols 9-25 are all space (0x20). This avoids showing aliased register entries.
- Handshake: a transfer occurs on an edge where char_valid&&char_ready. While char_valid=1 and char_ready=0, char_data, char_col and char_row hold stable. char_valid never drops without a transfer.
- On transfer at col<ROW_CHARS-1: col increments and state stays EMIT. A new character may transfer every cycle, so throughput is 1 char/clk when char_ready stays high.
- On transfer at col=ROW_CHARS-1 with row<NUM_ROWS-1: char_valid<=0, read_address<=row+1, state<=FETCH. This gives one bubble cycle per row.
- On transfer at col=ROW_CHARS-1 with row=NUM_ROWS-1: char_valid<=0, busy<=0, frame_done<=1 for one cycle, read_address<=0, state<=IDLE.
- frame_start coinciding with the frame_done cycle is accepted, since the block is already in IDLE at that point.
- Reset mid-frame aborts immediately. No frame_done pulse is produced, and the next frame restarts at row 0.
- char_row always equals read_address while in FETCH or EMIT.

Decomposition:
- Shared package vga_debug_pkg holds:
  - state enum (IDLE/FETCH/EMIT);
  - ASCII_SPACE, ASCII_ZERO, ASCII_A_MINUS_10 constants;
  - field bit positions and field start columns (0, 9, 18, 27);
  - ROW_CHARS default.
- Sub-module: vga_hex_to_ascii, a combinational 4-bit to 8-bit converter, instantiated once on the column-selected nibble.

Test Plan:
- Reset then idle: every output is 0. Pulse frame_start with ram_out instr=0x12345678, reg=0x9ABCDEF0, float=0x0000000F, data=0xDEADBEEF and char_ready=1.
  - char_valid rises 2 edges after frame_start.
  - Row 0 chars are "12345678 9ABCDEF0 0000000F DEADBEEF" with cols 0..34.
- Backpressure: toggle char_ready 1,0,0,1 mid-row. char_data/col stay constant while ready=0, no character is skipped or duplicated, and 35 transfers complete per row.
- Row 32 with NUM_ROWS=46: ram_out reg/float fields nonzero. Cols 9-25 are all 0x20, while instr and data are rendered normally.
- Full frame: char_ready=1 throughout. Exactly 46*35=1610 transfers, frame_done pulses once, busy falls the same cycle, and read_address returns to 0. frame_start pulses mid-frame are ignored.
- Reset mid-frame: assert rst_n=0 at row 5, col 12. All outputs clear asynchronously and no frame_done occurs. A new frame_start restarts at row 0, col 0.
